// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// ahblite_busmatrix_arbiter_rr
// Per-output-stage arbiter for the AHB-Lite bus matrix. Picks which input
// stage drives this output stage, using fixed or round-robin priority.
// The grant is held across fixed-length bursts, undefined-length INCR
// bursts and locked transfers.
//
// Handshake: HREADY_OUT is the single enable for every decision. On a rising
// HCLK edge with HREADY_OUT=1, the burst tracker and the grant both advance.
// With HREADY_OUT=0 all state holds, whatever REQ or HTRANS_OUT show.
// A beat is accepted when HREADY_OUT=1, HSEL_OUT=1 and HTRANS_OUT[1]=1.
module ahblite_busmatrix_arbiter_rr #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = 2,
  parameter int RR_MODE   = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] REQ,
  input  logic                 HREADY_OUT,
  input  logic                 HSEL_OUT,
  input  logic [1:0]           HTRANS_OUT,
  input  logic [2:0]           HBURST_OUT,
  input  logic                 HMASTLOCK_OUT,
  output logic [SEL_W-1:0]     PORT_SEL,
  output logic [NUM_PORTS-1:0] PORT_GRANT,
  output logic                 PORT_NOSEL,
  output logic [1:0]           arb_state
);

  // AHB transfer types
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  // AHB burst encodings
  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;
  localparam logic [2:0] BU_WRAP4  = 3'd2;
  localparam logic [2:0] BU_INCR4  = 3'd3;
  localparam logic [2:0] BU_WRAP8  = 3'd4;
  localparam logic [2:0] BU_INCR8  = 3'd5;

  // Owner index a round-robin search continues from after reset, so port 0
  // wins first.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_PORTS - 1);

  // One-hot seed used to decode the grant vector
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_NOSEL  = 2'd0,  // no input stage owns the output stage
    ST_OWNED  = 2'd1,  // granted, free to re-arbitrate on the next update
    ST_LOCKED = 2'd2   // granted, held by burst, INCR or HMASTLOCK
  } state_t;

  // Registered state
  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [3:0]           beats_q, beats_d;
  logic                 incr_q, incr_d;

  // Combinational helpers
  logic                 lock_d;
  logic                 req_any;
  logic [SEL_W-1:0]     win;
  logic                 found;
  int                   start_i;
  int                   idx;

  assign req_any = |REQ;

  // Burst tracker: count the beats left in a fixed burst, and flag an
  // undefined-length INCR burst that is still open.
  always_comb begin
    beats_d = beats_q;
    incr_d  = incr_q;
    if (HREADY_OUT) begin
      if (HSEL_OUT && (HTRANS_OUT == TR_NONSEQ)) begin
        // A new burst starts. This also covers a NONSEQ that arrives before
        // an earlier burst has finished.
        case (HBURST_OUT)
          BU_SINGLE, BU_INCR: beats_d = 4'd0;
          BU_WRAP4, BU_INCR4: beats_d = 4'd3;
          BU_WRAP8, BU_INCR8: beats_d = 4'd7;
          default:            beats_d = 4'd15;
        endcase
        incr_d = (HBURST_OUT == BU_INCR);
      end else if (HSEL_OUT && (HTRANS_OUT == TR_SEQ)) begin
        // Saturate at zero so a stray SEQ never wraps the counter.
        if (beats_q != 4'd0) begin
          beats_d = beats_q - 4'd1;
        end
      end else if (HTRANS_OUT == TR_IDLE) begin
        // IDLE on a ready cycle ends any burst early.
        beats_d = 4'd0;
        incr_d  = 1'b0;
      end
    end
    lock_d = (beats_d != 4'd0) | incr_d | HMASTLOCK_OUT;
  end

  // Winner search: fixed priority (lowest index) or round-robin, starting
  // just above the last owner. The wrap is modulo NUM_PORTS, so unused
  // indices of a non-power-of-two port count are never selected.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    start_i = 0;
    idx     = 0;
    if (RR_MODE != 0) begin
      start_i = (int'(last_q) >= NUM_PORTS - 1) ? 0 : int'(last_q) + 1;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = start_i + k;
        if (idx >= NUM_PORTS) begin
          idx = idx - NUM_PORTS;
        end
        if (!found && REQ[idx]) begin
          found = 1'b1;
          win   = SEL_W'(idx);
        end
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (REQ[k]) begin
          win = SEL_W'(k);
        end
      end
    end
  end

  // Grant FSM next state. A held lock keeps the owner even if it drops REQ.
  // Otherwise the arbiter re-arbitrates using this edge's REQ, so a lock
  // release and a competing request on the same edge hand over immediately.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    if (HREADY_OUT) begin
      if ((state_q != ST_NOSEL) && lock_d) begin
        state_d = ST_LOCKED;
      end else if (req_any) begin
        state_d = lock_d ? ST_LOCKED : ST_OWNED;
        sel_d   = win;
        last_d  = win;
        grant_d = ONE_HOT0 << win;
      end else begin
        // Nobody is asking. PORT_SEL parks on the last owner.
        state_d = ST_NOSEL;
        grant_d = '0;
      end
    end
  end

  // State registers; reset abandons any burst in progress.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_NOSEL;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      grant_q <= '0;
      beats_q <= 4'd0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      beats_q <= beats_d;
      incr_q  <= incr_d;
    end
  end

  assign PORT_SEL   = sel_q;
  assign PORT_GRANT = grant_q;
  assign PORT_NOSEL = (state_q == ST_NOSEL);
  assign arb_state  = state_q;

endmodule
